generations_cell: RTL
=====================

GENERATIONS_CELL -- requirements
Module: generations_cell

Interface
REQ-001 Parameter STATES, default 2, meaning number of cell states (2..16); 0 = dead, 1 = alive, 2..STATES-1 = dying.
REQ-002 Parameter AGE_W, default 8, meaning width of the stability age counter (1..16).
REQ-003 Derived SW = max(1, ceil(log2(STATES))) SHALL size all state buses.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset; cell reset when sampled 0 at a rising clk edge.
REQ-006 nbr  input  8  alive flags of the 8 neighbours, bit order n,ne,e,se,s,sw,w,nw.
REQ-007 birth  input  9  rule mask; bit k set = dead cell with k live neighbours is born.
REQ-008 survive  input  9  rule mask; bit k set = live cell with k live neighbours survives.
REQ-009 enb  input  1  generation step strobe; one step per cycle while high.
REQ-010 write  input  1  scan load enable.
REQ-011 wval  input  SW  state value loaded on write.
REQ-012 clr_changed  input  1  clears the sticky changed flag.
REQ-013 state  output  SW  registered current cell state.
REQ-014 alive  output  1  combinational, high iff state == 1.
REQ-015 alive_prev  output  1  registered alive value before the most recent step.
REQ-016 changed  output  1  registered sticky flag: some step altered state.
REQ-017 age  output  AGE_W  registered count of consecutive steps without a state change.

Function
REQ-018 Priority per edge SHALL be: reset low > write > enb > hold.
REQ-019 Live count SHALL be the popcount of nbr, 4 bits, range 0..8, computed combinationally.
REQ-020 Step from state 0: next = 1 if birth[count] else 0.
REQ-021 Step from state 1: next = 1 if survive[count]; else next = 0 when STATES == 2, next = 2 when STATES > 2.
REQ-022 Step from state s >= 2: next = s+1, wrapping to 0 when s == STATES-1; nbr, birth, survive ignored.
REQ-023 Step latency: next state visible on state/alive one cycle after enb sampled high.
REQ-024 On step, alive_prev SHALL take the pre-step alive value.
REQ-025 On step with next != state, age SHALL clear to 0 and changed SHALL set to 1.
REQ-026 On step with next == state, age SHALL increment, saturating at 2^AGE_W-1; changed unaffected by the step.
REQ-027 On write, state = wval if wval < STATES else 0; alive_prev = alive value of the loaded state; age = 0; changed unchanged by write.
REQ-028 When enb and write both high, write wins and no step occurs.
REQ-029 clr_changed high clears changed, except a step setting changed in the same cycle wins (changed = 1).
REQ-030 clr_changed SHALL act independently of write and enb but not of reset.
REQ-031 Hold (no reset, write, enb): state, alive_prev, age unchanged; only clr_changed may alter changed.
REQ-032 birth, survive, nbr changes between steps SHALL have no effect until the next step.

Reset
REQ-033 Reset low at an edge SHALL set state = 0, alive_prev = 0, changed = 0, age = 0, overriding write, enb, clr_changed.
REQ-034 Reset mid-run SHALL discard the dying sequence and age count; the first step after reset release evaluates from state 0.

Verification
REQ-035 STATES=2, birth=9'h008, survive=9'h00C, state 0, nbr=8'b0000_0111, enb pulse -> state 1, alive 1, alive_prev 0, changed 1, age 0.
REQ-036 STATES=2, same rules, state 1, nbr=8'h00, enb pulse -> state 0, alive_prev 1; then 3 steps with nbr=0 -> state 0, age 3.
REQ-037 STATES=4, state 1, nbr=8'hFF (count 8, survive bit 8 clear), 4 consecutive steps -> state 2, 3, 0, 0; age 0,0,0,1.
REQ-038 AGE_W=2, stable dead cell, 5 steps -> age 1,2,3,3,3 (saturates).
REQ-039 write=1, enb=1, wval=3 with STATES=3 -> state 0 (out of range), age 0, changed unchanged; wval=2 next cycle -> state 2.
REQ-040 changed=1, clr_changed=1 with step causing change -> changed stays 1; reset low with write=1, wval=1 -> all outputs 0.

Source files
------------

// File: rtl/generations_cell.sv
// Single cell of a Generations-family cellular automaton with
// scan load, sticky change flag and a saturating stability age.
module generations_cell #(
    parameter int STATES = 2,
    parameter int AGE_W  = 8,
    localparam int SW = (STATES > 2) ? $clog2(STATES) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       nbr,
    input  logic [8:0]       birth,
    input  logic [8:0]       survive,
    input  logic             enb,
    input  logic             write,
    input  logic [SW-1:0]    wval,
    input  logic             clr_changed,
    output logic [SW-1:0]    state,
    output logic             alive,
    output logic             alive_prev,
    output logic             changed,
    output logic [AGE_W-1:0] age
);

    localparam logic [SW-1:0] L_ALIVE  = SW'(1);
    localparam logic [SW-1:0] L_DYING  = (STATES > 2) ? SW'(2) : '0;
    localparam logic [SW-1:0] L_LAST   = SW'(STATES - 1);
    localparam logic [SW:0]   L_STATES = (SW + 1)'(STATES);

    logic [SW-1:0]    r_state;
    logic             r_alive_prev;
    logic             r_changed;
    logic [AGE_W-1:0] r_age;

    logic [3:0]    w_count;
    logic [SW-1:0] w_next;
    logic [SW-1:0] w_load;
    logic          w_diff;
    logic          w_step;

    always_comb begin
        w_count = '0;
        for (int i = 0; i < 8; i++) begin
            w_count = w_count + {3'b000, nbr[i]};
        end
    end

    // Dying states advance unconditionally; only 0 and 1 consult the rules.
    always_comb begin
        w_next = r_state;
        if (r_state == '0) begin
            w_next = birth[w_count] ? L_ALIVE : '0;
        end else if (r_state == L_ALIVE) begin
            if (survive[w_count]) begin
                w_next = L_ALIVE;
            end else begin
                w_next = (STATES == 2) ? '0 : L_DYING;
            end
        end else begin
            w_next = (r_state == L_LAST) ? '0 : r_state + L_ALIVE;
        end
    end

    assign w_load = ({1'b0, wval} < L_STATES) ? wval : '0;
    assign w_diff = (w_next != r_state);
    assign w_step = enb && !write;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= '0;
            r_alive_prev <= 1'b0;
            r_age        <= '0;
        end else if (write) begin
            r_state      <= w_load;
            r_alive_prev <= (w_load == L_ALIVE);
            r_age        <= '0;
        end else if (enb) begin
            r_state      <= w_next;
            r_alive_prev <= (r_state == L_ALIVE);
            if (w_diff) begin
                r_age <= '0;
            end else if (r_age != '1) begin
                r_age <= r_age + 1'b1;
            end
        end
    end

    // A change-causing step beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_changed <= 1'b0;
        end else if (w_step && w_diff) begin
            r_changed <= 1'b1;
        end else if (clr_changed) begin
            r_changed <= 1'b0;
        end
    end

    assign state      = r_state;
    assign alive      = (r_state == L_ALIVE);
    assign alive_prev = r_alive_prev;
    assign changed    = r_changed;
    assign age        = r_age;

endmodule
